// File: rtl/video_pkg.sv
// Shared video-path definitions: sample width, line geometry, 4:2:2 phase
// and extractor FSM encodings, and the BT.656 timing-reference preamble.
package video_pkg;

    localparam int SAMPLE_W          = 8;
    localparam int ACTIVE_PIXELS_525 = 720;

    // Position of a word within a Cb-Y0-Cr-Y1 co-sited group
    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Timing reference preamble FF 00 00, followed by the XY word
    localparam logic [9:0] BT656_PRE0 = 10'h3FF;
    localparam logic [9:0] BT656_PRE1 = 10'h000;
    localparam logic [9:0] BT656_PRE2 = 10'h000;

    // Phases wrap Y1 -> Cb naturally in two bits
    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/active_video_extractor_assembler.sv
// Turns the accepted Cb/Y0/Cr/Y1 word sequence into per-pixel {Y,Cb,Cr}.
// Both luma samples of a pair share the Cb/Cr captured in the same group.
module cbycr_pixel_assembler
    import video_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          accept,
    input  logic          restart,
    input  logic [SW-1:0] word,
    output logic [1:0]    phase,
    output logic          pix_valid,
    output logic [SW-1:0] pix_y,
    output logic [SW-1:0] pix_cb,
    output logic [SW-1:0] pix_cr
);

    phase_t        phase_q;
    phase_t        cur_phase;
    logic [SW-1:0] cb_q;
    logic [SW-1:0] y0_q;
    logic [SW-1:0] cr_q;

    // A restart forces the current word to be treated as Cb of a new group
    assign cur_phase = restart ? PH_CB : phase_q;
    assign phase     = cur_phase;

    // Capture chroma/luma and emit a pixel on each Cr and Y1 word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_CB;
            cb_q      <= '0;
            y0_q      <= '0;
            cr_q      <= '0;
            pix_valid <= 1'b0;
            pix_y     <= '0;
            pix_cb    <= '0;
            pix_cr    <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (accept) begin
                phase_q <= next_phase(cur_phase);
                case (cur_phase)
                    PH_CB: cb_q <= word;
                    PH_Y0: y0_q <= word;
                    PH_CR: begin
                        cr_q      <= word;
                        pix_valid <= 1'b1;
                        pix_y     <= y0_q;
                        pix_cb    <= cb_q;
                        pix_cr    <= word;
                    end
                    PH_Y1: begin
                        pix_valid <= 1'b1;
                        pix_y     <= word;
                        pix_cb    <= cb_q;
                        pix_cr    <= cr_q;
                    end
                    default: ;
                endcase
            end else if (restart) begin
                // Aborted line: drop any partial group
                phase_q <= PH_CB;
            end
        end
    end

endmodule

// File: rtl/active_video_extractor.sv
// Active-video extractor: detects SAV/EAV from the sync parser flags, gates
// the 2*ACTIVE_PIXELS sample window, and tracks pixel column, field and
// field-relative active line. Malformed (short) lines are flagged.
module active_video_extractor
    import video_pkg::*;
#(
    parameter int SAMPLE_W      = 8,
    parameter int ACTIVE_PIXELS = ACTIVE_PIXELS_525,
    parameter int X_W           = 11,
    parameter int Y_W           = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [9:0]          bt656,
    input  logic                H,
    input  logic                V,
    input  logic                F,
    output logic                pix_valid,
    output logic [SAMPLE_W-1:0] pix_y,
    output logic [SAMPLE_W-1:0] pix_cb,
    output logic [SAMPLE_W-1:0] pix_cr,
    output logic [X_W-1:0]      pix_x,
    output logic [Y_W-1:0]      line_y,
    output logic                field,
    output logic                line_start,
    output logic                field_start,
    output logic                err_short_line
);

    localparam int                WORDS     = 2 * ACTIVE_PIXELS;
    localparam int                CNT_W     = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [Y_W-1:0]    LINE_MAX  = '1;

    state_t           state;
    state_t           state_nxt;
    logic             h_prev;
    logic             v_prev;
    logic             h_fall;
    logic             h_rise;
    logic             v_fall;
    logic             v_rise;
    logic [CNT_W-1:0] word_cnt;
    logic             accept;
    logic             restart;
    logic             start_line;
    logic             line_end;
    logic             abort;
    logic [1:0]       cur_phase;
    logic             unused_low_bits;

    // Sub-sample bits below the sample field carry no information here
    assign unused_low_bits = ^bt656[9-SAMPLE_W:0];

    assign h_fall = h_prev & ~H;
    assign h_rise = ~h_prev & H;
    assign v_fall = v_prev & ~V;
    assign v_rise = ~v_prev & V;

    // Flag history for edge detection; starts high so blanking is assumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_prev <= 1'b1;
            v_prev <= 1'b1;
        end else begin
            h_prev <= H;
            v_prev <= V;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Line window control: start on SAV in active field, end on count or abort
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        restart    = 1'b0;
        start_line = 1'b0;
        line_end   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (h_fall && !V) begin
                    state_nxt  = ST_ACTIVE;
                    accept     = 1'b1;
                    restart    = 1'b1;
                    start_line = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (h_rise || v_rise) begin
                    state_nxt = ST_IDLE;
                    restart   = 1'b1;
                    abort     = 1'b1;
                    line_end  = 1'b1;
                end else begin
                    accept = 1'b1;
                    if (word_cnt == LAST_WORD) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (h_rise) begin
                    state_nxt = ST_IDLE;
                    line_end  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index of the word being accepted; word 0 is taken at line start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        word_cnt <= '0;
        else if (start_line) word_cnt <= CNT_W'(1);
        else if (accept)     word_cnt <= word_cnt + 1'b1;
    end

    cbycr_pixel_assembler #(
        .SW (SAMPLE_W)
    ) u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .accept    (accept),
        .restart   (restart),
        .word      (bt656[9 -: SAMPLE_W]),
        .phase     (cur_phase),
        .pix_valid (pix_valid),
        .pix_y     (pix_y),
        .pix_cb    (pix_cb),
        .pix_cr    (pix_cr)
    );

    // Column of the emitted pixel: group index * 2, plus 1 for the Y1 pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_x <= '0;
        end else if (accept && (cur_phase == PH_CR || cur_phase == PH_Y1)) begin
            pix_x <= X_W'({word_cnt[CNT_W-1:2], cur_phase == PH_Y1});
        end
    end

    // Field latch and saturating active-line counter; field start wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_y <= '0;
            field  <= 1'b0;
        end else if (v_fall) begin
            line_y <= '0;
            field  <= F;
        end else if (line_end && line_y != LINE_MAX) begin
            line_y <= line_y + 1'b1;
        end
    end

    // Registered event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_start     <= 1'b0;
            field_start    <= 1'b0;
            err_short_line <= 1'b0;
        end else begin
            line_start     <= start_line;
            field_start    <= v_fall;
            err_short_line <= abort;
        end
    end

endmodule
